// File: rtl/pac_counter_writeback.sv
// Streams the page-access-counter SRAM to host memory as 512-bit AXI INCR bursts.
// A fetcher packs counter words into a 2-entry beat FIFO; a control FSM drains it burst by burst.
module pac_counter_writeback #(
    parameter int SRAM_ADDR_WIDTH = 12,
    parameter int SRAM_DATA_WIDTH = 32,
    parameter int SRAM_RD_LAT     = 2,
    parameter int BURST_BEATS     = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       csr_write_back,
    input  logic [63:0]                write_back_addr,
    output logic                       is_writing_back,
    output logic                       wb_done,
    output logic                       wb_error,
    output logic                       counter_buf_rden,
    output logic [SRAM_ADDR_WIDTH-1:0] counter_buf_rdaddress,
    input  logic [SRAM_DATA_WIDTH-1:0] counter_buf_rdata,
    output logic [11:0]                awid,
    output logic [63:0]                awaddr,
    output logic [9:0]                 awlen,
    output logic [2:0]                 awsize,
    output logic [1:0]                 awburst,
    output logic                       awvalid,
    input  logic                       awready,
    output logic [511:0]               wdata,
    output logic [63:0]                wstrb,
    output logic                       wlast,
    output logic                       wvalid,
    input  logic                       wready,
    input  logic [11:0]                bid,
    input  logic [1:0]                 bresp,
    input  logic                       bvalid,
    output logic                       bready
);
    localparam int NUM_WORDS  = 1 << SRAM_ADDR_WIDTH;
    localparam int WPB        = 512 / SRAM_DATA_WIDTH;
    localparam int NUM_BEATS  = NUM_WORDS / WPB;
    localparam int NUM_BURSTS = NUM_BEATS / BURST_BEATS;
    localparam int ALIGN_W    = $clog2(BURST_BEATS * 64);
    localparam int WOFF_W     = (WPB > 1) ? $clog2(WPB) : 1;
    localparam int BEAT_W     = (BURST_BEATS > 1) ? $clog2(BURST_BEATS) : 1;
    localparam int BURST_W    = (NUM_BURSTS > 1) ? $clog2(NUM_BURSTS) : 1;

    typedef logic [WPB-1:0][SRAM_DATA_WIDTH-1:0] beat_t;
    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_RESP, S_DONE} state_e;

    state_e                     state_q, state_d;
    logic [63:0]                base_q, base_d;
    logic [BURST_W-1:0]         burst_idx_q, burst_idx_d;
    logic [BEAT_W-1:0]          beat_idx_q, beat_idx_d;
    logic                       wb_error_q, wb_error_d;

    logic                       fetch_on_q, fetch_on_d;
    logic [SRAM_ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic [SRAM_RD_LAT-1:0]     vld_pipe_q, vld_pipe_d;
    logic [SRAM_RD_LAT:0]       vld_pipe;
    logic [WOFF_W-1:0]          cap_idx_q, cap_idx_d;
    beat_t                      beat_asm_q, beat_asm_d;
    beat_t                      beat_full;

    logic [1:0][511:0]          fifo_mem_q, fifo_mem_d;
    logic                       fifo_wr_q, fifo_wr_d;
    logic                       fifo_rd_q, fifo_rd_d;
    logic [1:0]                 fifo_cnt_q, fifo_cnt_d;
    logic [1:0]                 inflight_q, inflight_d;

    logic       start, rden, at_beat_start, cap, push, pop, w_ok, last_beat;
    logic [2:0] reserved;

    always_comb begin
        start         = (state_q == S_IDLE) && csr_write_back;
        at_beat_start = (rd_addr_q & SRAM_ADDR_WIDTH'(WPB - 1)) == '0;
        // A beat is reserved against FIFO space when its first word is read;
        // the rest of that beat then issues back to back.
        reserved      = {1'b0, fifo_cnt_q} + {1'b0, inflight_q};
        rden          = fetch_on_q && (!at_beat_start || (reserved < 3'd2));
        vld_pipe      = {vld_pipe_q, rden};
        cap           = vld_pipe[SRAM_RD_LAT];
        push          = cap && (cap_idx_q == WOFF_W'(WPB - 1));
        w_ok          = (state_q == S_DATA) && (fifo_cnt_q != 2'd0);
        pop           = w_ok && wready;
        last_beat     = beat_idx_q == BEAT_W'(BURST_BEATS - 1);
        beat_full            = beat_asm_q;
        beat_full[cap_idx_q] = counter_buf_rdata;
    end

    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        burst_idx_d = burst_idx_q;
        beat_idx_d  = beat_idx_q;
        wb_error_d  = wb_error_q;
        fetch_on_d  = fetch_on_q;
        rd_addr_d   = rd_addr_q;
        vld_pipe_d  = vld_pipe[SRAM_RD_LAT-1:0];
        cap_idx_d   = cap_idx_q;
        beat_asm_d  = beat_asm_q;
        fifo_mem_d  = fifo_mem_q;
        fifo_wr_d   = fifo_wr_q;
        fifo_rd_d   = fifo_rd_q;
        fifo_cnt_d  = fifo_cnt_q + 2'(push) - 2'(pop);
        inflight_d  = inflight_q + 2'(rden && at_beat_start) - 2'(push);

        if (rden) begin
            rd_addr_d = rd_addr_q + 1'b1;
            if (rd_addr_q == SRAM_ADDR_WIDTH'(NUM_WORDS - 1))
                fetch_on_d = 1'b0;
        end
        if (cap) begin
            beat_asm_d = beat_full;
            cap_idx_d  = (cap_idx_q == WOFF_W'(WPB - 1)) ? '0 : cap_idx_q + 1'b1;
        end
        if (push) begin
            fifo_mem_d[fifo_wr_q] = beat_full;
            fifo_wr_d             = ~fifo_wr_q;
        end
        if (pop)
            fifo_rd_d = ~fifo_rd_q;

        case (state_q)
            S_ADDR: if (awready) state_d = S_DATA;
            S_DATA: begin
                if (pop) begin
                    beat_idx_d = last_beat ? '0 : beat_idx_q + 1'b1;
                    if (last_beat) state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (bvalid) begin
                    if (bresp != 2'b00) wb_error_d = 1'b1;
                    if (burst_idx_q == BURST_W'(NUM_BURSTS - 1)) begin
                        state_d = S_DONE;
                    end else begin
                        burst_idx_d = burst_idx_q + 1'b1;
                        state_d     = S_ADDR;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = state_q;
        endcase

        if (start) begin
            state_d     = S_ADDR;
            base_d      = {write_back_addr[63:ALIGN_W], ALIGN_W'(0)};
            burst_idx_d = '0;
            beat_idx_d  = '0;
            wb_error_d  = 1'b0;
            fetch_on_d  = 1'b1;
            rd_addr_d   = '0;
            vld_pipe_d  = '0;
            cap_idx_d   = '0;
            fifo_wr_d   = 1'b0;
            fifo_rd_d   = 1'b0;
            fifo_cnt_d  = '0;
            inflight_d  = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            base_q      <= '0;
            burst_idx_q <= '0;
            beat_idx_q  <= '0;
            wb_error_q  <= 1'b0;
            fetch_on_q  <= 1'b0;
            rd_addr_q   <= '0;
            vld_pipe_q  <= '0;
            cap_idx_q   <= '0;
            beat_asm_q  <= '0;
            fifo_mem_q  <= '0;
            fifo_wr_q   <= 1'b0;
            fifo_rd_q   <= 1'b0;
            fifo_cnt_q  <= '0;
            inflight_q  <= '0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            burst_idx_q <= burst_idx_d;
            beat_idx_q  <= beat_idx_d;
            wb_error_q  <= wb_error_d;
            fetch_on_q  <= fetch_on_d;
            rd_addr_q   <= rd_addr_d;
            vld_pipe_q  <= vld_pipe_d;
            cap_idx_q   <= cap_idx_d;
            beat_asm_q  <= beat_asm_d;
            fifo_mem_q  <= fifo_mem_d;
            fifo_wr_q   <= fifo_wr_d;
            fifo_rd_q   <= fifo_rd_d;
            fifo_cnt_q  <= fifo_cnt_d;
            inflight_q  <= inflight_d;
        end
    end

    assign is_writing_back       = (state_q == S_ADDR) || (state_q == S_DATA) || (state_q == S_RESP);
    assign wb_done               = (state_q == S_DONE);
    assign wb_error              = wb_error_q;
    assign counter_buf_rden      = rden;
    assign counter_buf_rdaddress = rd_addr_q;

    assign awid    = '0;
    assign awaddr  = base_q + (64'(burst_idx_q) << ALIGN_W);
    assign awlen   = 10'(BURST_BEATS - 1);
    assign awsize  = 3'b110;
    assign awburst = 2'b01;
    assign awvalid = (state_q == S_ADDR);
    assign wdata   = fifo_mem_q[fifo_rd_q];
    assign wstrb   = '1;
    assign wvalid  = w_ok;
    assign wlast   = w_ok && last_beat;
    assign bready  = (state_q == S_RESP);

    logic unused_ok;
    assign unused_ok = ^{bid, write_back_addr[ALIGN_W-1:0]};
endmodule

// File: tb/tb_pac_counter_writeback.sv
// Directed bench for pac_counter_writeback: SRAM model, AXI sink and a scoreboard
// of expected AW addresses and beats filled at each accepted start.
module tb_pac_counter_writeback;
    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         csr_write_back;
    logic [63:0]  write_back_addr;
    logic         is_writing_back, wb_done, wb_error;
    logic         counter_buf_rden;
    logic [11:0]  counter_buf_rdaddress;
    logic [31:0]  counter_buf_rdata;
    logic [11:0]  awid;
    logic [63:0]  awaddr;
    logic [9:0]   awlen;
    logic [2:0]   awsize;
    logic [1:0]   awburst;
    logic         awvalid, awready;
    logic [511:0] wdata;
    logic [63:0]  wstrb;
    logic         wlast, wvalid, wready;
    logic [11:0]  bid;
    logic [1:0]   bresp;
    logic         bvalid, bready;

    always #5 clk = ~clk;

    pac_counter_writeback dut (
        .clk(clk), .reset(reset), .csr_write_back(csr_write_back),
        .write_back_addr(write_back_addr), .is_writing_back(is_writing_back),
        .wb_done(wb_done), .wb_error(wb_error), .counter_buf_rden(counter_buf_rden),
        .counter_buf_rdaddress(counter_buf_rdaddress), .counter_buf_rdata(counter_buf_rdata),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .wvalid(wvalid), .wready(wready), .bid(bid), .bresp(bresp), .bvalid(bvalid),
        .bready(bready)
    );

    // Two-cycle SRAM: word i reads as i ^ xor_key
    logic [31:0] xor_key = 32'h0;
    logic [31:0] sram_s1;
    always @(posedge clk) begin
        sram_s1           <= counter_buf_rden ? (32'(counter_buf_rdaddress) ^ xor_key) : 32'hDEAD_BEEF;
        counter_buf_rdata <= sram_s1;
    end

    int checks = 0;
    int errors = 0;
    logic [63:0] aw_q[$];
    int          beat_q[$];

    logic        in_run = 1'b0, start_req = 1'b0, wr_toggle = 1'b0, pause_seen = 1'b0;
    logic        aw_stall_prev = 1'b0, w_stall_prev = 1'b0, err_at_done = 1'b0;
    logic [63:0] start_addr = 64'h0, prev_awaddr = 64'h0;
    logic [511:0] prev_wdata = '0;
    int aw_hold = 0, err_burst = -1, exp_rd_addr = 0;
    int run_aw = 0, run_beats = 0, run_resp = 0, run_done = 0, total_done = 0;
    int since = 0, first_w_lat = -1;

    task automatic chk(input string tag, input logic [639:0] obs, input logic [639:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [511:0] exp_beat(input int b);
        logic [511:0] r;
        for (int k = 0; k < 16; k++) r[k*32 +: 32] = 32'(b * 16 + k) ^ xor_key;
        return r;
    endfunction

    task automatic monitor();
        int idx;
        if (in_run) since++;
        chk("is_writing_back", 640'(is_writing_back), 640'(in_run && !wb_done));
        if (counter_buf_rden) begin
            chk("rd_addr", {exp_rd_addr < 4096, counter_buf_rdaddress}, {1'b1, 12'(exp_rd_addr)});
            exp_rd_addr++;
        end else if (in_run && exp_rd_addr > 0 && exp_rd_addr < 4096) begin
            pause_seen = 1'b1;
        end
        if (aw_stall_prev) chk("aw_hold", {awvalid, awaddr}, {1'b1, prev_awaddr});
        aw_stall_prev = awvalid && !awready;
        prev_awaddr   = awaddr;
        if (w_stall_prev) chk("w_hold", {wvalid, wdata}, {1'b1, prev_wdata});
        w_stall_prev = wvalid && !wready;
        prev_wdata   = wdata;
        if (wvalid && first_w_lat < 0) first_w_lat = since;

        if (awvalid && awready) begin
            if (aw_q.size() == 0) chk("aw_unexpected", 640'(0), 640'(1));
            else chk("aw", {awaddr, awlen, awsize, awburst, awid}, {aw_q.pop_front(), 10'd15, 3'b110, 2'b01, 12'h0});
            chk("aw_outstanding", 640'(run_aw), 640'(run_resp));
            run_aw++;
        end
        if (wvalid && wready) begin
            if (beat_q.size() == 0) chk("w_unexpected", 640'(0), 640'(1));
            else begin
                idx = beat_q.pop_front();
                chk("w_beat", {wdata, wlast, wstrb}, {exp_beat(idx), (idx % 16) == 15, 64'hFFFF_FFFF_FFFF_FFFF});
            end
            run_beats++;
        end
        if (bvalid && bready) begin
            chk("b_after_burst", 640'(run_beats), 640'((run_resp + 1) * 16));
            run_resp++;
        end
        if (wb_done) begin
            chk("done_in_run", 640'(in_run), 640'(1));
            run_done++;
            total_done++;
            err_at_done = wb_error;
            in_run      = 1'b0;
        end
    endtask

    task automatic cycle();
        logic [63:0] base;
        @(negedge clk);
        wready  = wr_toggle ? ~wready : 1'b1;
        awready = (aw_hold > 0) ? 1'b0 : 1'b1;
        if (aw_hold > 0) aw_hold--;
        bresp          = (run_resp == err_burst) ? 2'b10 : 2'b00;
        csr_write_back = start_req;
        if (start_req) write_back_addr = start_addr;
        #1;
        monitor();
        if (start_req) begin
            if (!in_run) begin
                base = start_addr & ~64'h3FF;
                aw_q.delete();
                beat_q.delete();
                for (int n = 0; n < 16; n++) aw_q.push_back(base + 64'(n) * 64'h400);
                for (int b = 0; b < 256; b++) beat_q.push_back(b);
                exp_rd_addr = 0; run_aw = 0; run_beats = 0; run_resp = 0; run_done = 0;
                since = 0; first_w_lat = -1; pause_seen = 1'b0;
                in_run = 1'b1;
            end
            start_req = 1'b0;
        end
    endtask

    task automatic wait_done(input string tag);
        int n  = 0;
        int d0 = total_done;
        while (total_done == d0 && n < 8000) begin
            cycle();
            n++;
        end
        chk({tag, "_timeout"}, 640'(total_done != d0), 640'(1));
    endtask

    task automatic end_run(input string tag);
        chk({tag, "_totals"},
            {32'(run_aw), 32'(run_beats), 32'(run_resp), 32'(run_done), 32'(aw_q.size()), 32'(beat_q.size()), 32'(exp_rd_addr)},
            {32'd16, 32'd256, 32'd16, 32'd1, 32'd0, 32'd0, 32'd4096});
    endtask

    initial begin
        int n;
        csr_write_back = 1'b0; write_back_addr = '0;
        awready = 1'b1; wready = 1'b1; bvalid = 1'b1; bresp = 2'b00; bid = '0;

        repeat (3) @(negedge clk);
        #1;
        chk("reset_outputs",
            {is_writing_back, wb_done, wb_error, counter_buf_rden, awvalid, wvalid, wlast, bready,
             awaddr, awid, awlen, awsize, awburst, wstrb},
            {8'h00, 64'h0, 12'h0, 10'd15, 3'b110, 2'b01, 64'hFFFF_FFFF_FFFF_FFFF});
        @(negedge clk);
        reset = 1'b0;
        repeat (2) cycle();

        // A: basic stream, all channels always ready
        start_addr = 64'h1_0000; start_req = 1'b1;
        wait_done("runA");
        end_run("runA");
        chk("first_wvalid_latency", 640'(first_w_lat > 0 && first_w_lat <= 19), 640'(1));
        chk("runA_error", 640'(err_at_done), 640'(0));

        // B: error response on burst 5 only
        xor_key = 32'hA5A5_0000; err_burst = 5;
        start_addr = 64'h2000_0000; start_req = 1'b1;
        wait_done("runB");
        end_run("runB");
        chk("runB_error_at_done", 640'(err_at_done), 640'(1));
        err_burst = -1;
        repeat (3) cycle();
        chk("error_sticky", 640'(wb_error), 640'(1));

        // C: unaligned base, restart clears error, second start ignored
        xor_key = 32'h0000_F00D;
        start_addr = 64'h1_0123; start_req = 1'b1;
        cycle();
        cycle();
        chk("error_cleared", 640'(wb_error), 640'(0));
        n = 0;
        while (run_beats < 5 && n < 200) begin cycle(); n++; end
        chk("reach_data", 640'(run_beats >= 5), 640'(1));
        start_addr = 64'h9_0000; start_req = 1'b1;
        cycle();
        chk("busy_after_2nd_start", 640'(is_writing_back), 640'(1));
        wait_done("runC");
        end_run("runC");

        // D: wready toggling, AW held off so the beat FIFO fills
        xor_key = 32'h1234_5678; wr_toggle = 1'b1; aw_hold = 50;
        start_addr = 64'h40_0000; start_req = 1'b1;
        wait_done("runD");
        end_run("runD");
        chk("rden_paused", 640'(pause_seen), 640'(1));
        wr_toggle = 1'b0; wready = 1'b1;

        // E: reset in the middle of burst 3
        xor_key = 32'h0;
        start_addr = 64'h3_0000; start_req = 1'b1;
        n = 0;
        while (!(run_aw == 4 && run_beats >= 52) && n < 3000) begin cycle(); n++; end
        chk("reach_burst3", 640'(run_aw == 4 && run_beats >= 52), 640'(1));
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("async_reset", {awvalid, wvalid, counter_buf_rden, is_writing_back}, 640'(0));
        in_run = 1'b0; aw_q.delete(); beat_q.delete();
        aw_stall_prev = 1'b0; w_stall_prev = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (2) cycle();

        // F: fresh start after reset, address arithmetic wraps past 2^64
        xor_key = 32'h0BAD_CAFE;
        start_addr = 64'hFFFF_FFFF_FFFF_F000; start_req = 1'b1;
        wait_done("runF");
        end_run("runF");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pac_counter_writeback.md
Name: pac_counter_writeback

Overview:
- Reader-side counterpart of the page-access-counter SRAM writer.
- On a CSR write-back request it reads every counter word out of the counter buffer SRAM and packs 16 words per 512-bit beat.
- It streams the whole buffer to host memory at write_back_addr as AXI-MM INCR write bursts, then reports completion.
- Sits between the PAC control logic and the AXI write channels of the PAC slice.

Parameters:
- SRAM_ADDR_WIDTH, 12, counter buffer word-address width; NUM_WORDS = 2**SRAM_ADDR_WIDTH.
- SRAM_DATA_WIDTH, 32, counter word width; 512 must be a multiple of it; WPB = 512/SRAM_DATA_WIDTH words per beat.
- SRAM_RD_LAT, 2, cycles from counter_buf_rden to valid counter_buf_rdata.
- BURST_BEATS, 16, beats per AXI burst; NUM_WORDS/WPB must be a multiple of it.

Ports:
- clk  in  1  single clock.
- reset  in  1  asynchronous, active-high reset.
- csr_write_back  in  1  one-cycle start pulse.
- write_back_addr  in  64  destination byte address, sampled at start.
- is_writing_back  out  1  high from the cycle after the accepted start until done.
- wb_done  out  1  one-cycle completion pulse.
- wb_error  out  1  sticky: some bresp != 0 since the last start.
- counter_buf_rden  out  1  SRAM read enable.
- counter_buf_rdaddress  out  SRAM_ADDR_WIDTH  SRAM word address.
- counter_buf_rdata  in  SRAM_DATA_WIDTH  SRAM read data.
- awid  out  12  constant 0.
- awaddr  out  64  burst byte address.
- awlen  out  10  constant BURST_BEATS-1.
- awsize  out  3  constant 3'b110 (64 B).
- awburst  out  2  constant 2'b01 (INCR).
- awvalid  out  1  write address valid.
- awready  in  1  write address ready.
- wdata  out  512  beat data.
- wstrb  out  64  all ones.
- wlast  out  1  last beat of a burst.
- wvalid  out  1  write data valid.
- wready  in  1  write data ready.
- bid  in  12  ignored.
- bresp  in  2  write response.
- bvalid  in  1  write response valid.
- bready  out  1  write response ready.
- Remaining AXI AW/W attributes (awprot, awqos, awuser, awcache, awlock, awregion, awatop, wuser) are tied to 0 at integration.

Behaviour:
- Reset values: all outputs 0 except the constants listed above; FSM in IDLE; beat buffer empty; all counters 0.
- Control FSM:
  - IDLE: on csr_write_back, latch base = write_back_addr with bits [log2(BURST_BEATS*64)-1:0] forced to 0, clear wb_error, go to ADDR.
  - csr_write_back in any other state is ignored.
  - ADDR: awvalid=1, awaddr = base + burst_idx*BURST_BEATS*64. Hold awvalid and awaddr stable until awready; then go to DATA.
  - DATA: present beats from the buffer. wvalid = buffer non-empty. A beat transfers on wvalid&wready. wlast=1 on beat BURST_BEATS-1 of the burst. After the wlast handshake go to RESP.
  - RESP: bready=1. On bvalid, if bresp != 0 set wb_error. If burst_idx is the last burst, go to DONE; otherwise burst_idx++ and go to ADDR. Only one burst is outstanding at a time.
  - DONE: wb_done=1 for one cycle, then IDLE. is_writing_back deasserts in the same cycle wb_done asserts.
- Fetcher:
  - Runs independently from the cycle after start, including during ADDR and RESP.
  - Issues one SRAM read per cycle in address order 0..NUM_WORDS-1, but only while (buffered beats + beats in flight) < 2.
  - Pipelined rden markers SRAM_RD_LAT deep capture rdata.
  - Word k of a beat lands in wdata[SRAM_DATA_WIDTH*k +: SRAM_DATA_WIDTH], so word address = beat*WPB + k.
  - A beat is pushed into a 2-entry beat FIFO when word WPB-1 is captured.
  - rden stops after word NUM_WORDS-1.
  - The FIFO never overflows; wdata is held stable while wvalid&!wready.
- Throughput: with wready tied to 1, steady state is one beat per WPB cycles (SRAM-bound). First wvalid appears no later than WPB+SRAM_RD_LAT+1 cycles after start.
- Address arithmetic is 64-bit wrap-around; no 4 KB crossing occurs because bursts are BURST_BEATS*64 aligned.
- Reset mid-operation: immediate return to the reset state; partial AXI transactions are abandoned, as reset is system-wide.

Test Plan:
- Defaults, SRAM word i = i, csr_write_back with write_back_addr=0x1_0000, wready/awready/bvalid always ready → 16 AW at 0x1_0000 + n*0x400, awlen=15; 256 beats; beat 0 wdata[31:0]=0 and [511:480]=15; wlast every 16th beat; one wb_done.
- write_back_addr=0x1_0123 → first awaddr=0x1_0000.
- wready toggling 1/0 every cycle → wdata stable across stalls; all 256 beats in order; counter_buf_rden pauses when the buffer is full.
- bresp=2'b10 on burst 5 only → wb_error=1 at done; all 16 bursts still issued; a new start clears wb_error.
- Second csr_write_back during DATA → ignored; exactly 16 AW total; is_writing_back stays high.
- reset asserted mid-burst 3 → awvalid, wvalid, rden and is_writing_back drop to 0 asynchronously; a fresh start afterwards restarts at burst 0.
